// File: rtl/instruction_fetch_if.sv
// Instruction memory request/response bus used by instruction_fetch.
// master: fetch unit (drives request), slave: instruction memory.
interface instruction_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: single-outstanding request to instruction memory,
// IF/ID pipeline register, stall hold buffer, redirect/flush squashing.
// Optional performance counters (fetch_cnt, stall_cnt) are built when the
// macro IFETCH_PERF_CNT_EN is defined.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pc_src,
    input  logic [31:0]         pc_branch,
    input  logic                if_stall,
    input  logic                if_flush,
    instruction_fetch_if.master imem,
    output logic [31:0]         IF_ID_pc,
    output logic [31:0]         IF_ID_inst,
    output logic [4:0]          IF_ID_rs1,
    output logic [4:0]          IF_ID_rs2,
    output logic                IF_ID_valid
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]         fetch_cnt,
    output logic [31:0]         stall_cnt
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state;
    logic [31:0] pc;          // address of the request being issued or outstanding
    logic [31:0] pc_plus4;
    logic [31:0] hold_inst;
    logic        squash;

    logic        kill;         // redirect or flush this cycle
    logic        resp;         // response for the outstanding request arrives
    logic        deliver;      // in-order response goes straight into IF/ID
    logic        reissue;      // new request issued in the response cycle
    logic        release_hold; // held instruction goes into IF/ID

    // Response decode and combinational request path
    always_comb begin
        kill         = pc_src | if_flush;
        pc_plus4     = pc + 32'd4;
        resp         = (state == WAIT) && imem.imem_rvalid;
        deliver      = resp && !squash && !kill && !if_stall;
        // A squashed response is dropped and refetched at once, even while stalled
        reissue      = resp && !kill && (squash || !if_stall);
        release_hold = (state == HOLD) && !if_stall && !kill;
        imem.imem_req  = (state == REQ) || reissue;
        imem.imem_addr = deliver ? pc_plus4 : pc;
    end

    assign IF_ID_rs1 = IF_ID_inst[19:15];
    assign IF_ID_rs2 = IF_ID_inst[24:20];

    // Fetch FSM, PC, hold buffer and IF/ID register
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            hold_inst   <= '0;
            squash      <= 1'b0;
            IF_ID_pc    <= '0;
            IF_ID_inst  <= NOP;
            IF_ID_valid <= 1'b0;
        end else begin
            if (kill) begin
                IF_ID_pc    <= '0;
                IF_ID_inst  <= NOP;
                IF_ID_valid <= 1'b0;
            end else if (deliver) begin
                IF_ID_pc    <= pc;
                IF_ID_inst  <= imem.imem_rdata;
                IF_ID_valid <= 1'b1;
            end else if (release_hold) begin
                IF_ID_pc    <= pc;
                IF_ID_inst  <= hold_inst;
                IF_ID_valid <= 1'b1;
            end else if (!if_stall) begin
                IF_ID_valid <= 1'b0;
            end

            if (pc_src) begin
                pc <= pc_branch & ~32'd3;
            end else if (deliver || release_hold) begin
                pc <= pc_plus4;
            end

            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (imem.imem_gnt) begin
                        state  <= WAIT;
                        squash <= kill;
                    end
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        squash <= 1'b0;
                        if (reissue) begin
                            state <= imem.imem_gnt ? WAIT : REQ;
                        end else if (kill) begin
                            state <= REQ;
                        end else begin
                            // Stalled in-order response: park it, no refetch later
                            state     <= HOLD;
                            hold_inst <= imem.imem_rdata;
                        end
                    end else if (kill) begin
                        squash <= 1'b1;
                    end
                end
                HOLD: begin
                    if (kill || !if_stall) begin
                        state <= REQ;
                    end
                end
            endcase
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    // Fetch and stall event counters, wrapping silently
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (deliver || release_hold) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (if_stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_src;
    logic [31:0] pc_branch;
    logic        if_stall;
    logic        if_flush;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_inst;
    logic [4:0]  IF_ID_rs1;
    logic [4:0]  IF_ID_rs2;
    logic        IF_ID_valid;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    instruction_fetch_if bus ();

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_src      (pc_src),
        .pc_branch   (pc_branch),
        .if_stall    (if_stall),
        .if_flush    (if_flush),
        .imem        (bus),
        .IF_ID_pc    (IF_ID_pc),
        .IF_ID_inst  (IF_ID_inst),
        .IF_ID_rs1   (IF_ID_rs1),
        .IF_ID_rs2   (IF_ID_rs2),
        .IF_ID_valid (IF_ID_valid)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem(input logic gnt, input logic rvalid, input logic [31:0] rdata);
        bus.imem_gnt    = gnt;
        bus.imem_rvalid = rvalid;
        bus.imem_rdata  = rdata;
        #1;
    endtask

    initial begin
        reset = 1'b1; pc_src = 1'b0; pc_branch = '0; if_stall = 1'b0; if_flush = 1'b0;
        mem(1'b0, 1'b0, '0);
        tick(); tick();
        check("rst_req", bus.imem_req, 0);
        check("rst_addr", bus.imem_addr, 32'h0);
        check("rst_inst", IF_ID_inst, 32'h13);
        check("rst_valid", IF_ID_valid, 0);
        check("rst_pc", IF_ID_pc, 32'h0);
        check("rst_rs1", IF_ID_rs1, 0);
`ifdef IFETCH_PERF_CNT_EN
        check("rst_fetch_cnt", fetch_cnt, 0);
        check("rst_stall_cnt", stall_cnt, 0);
`endif

        // Back-to-back fetch with a 1-cycle memory
        reset = 1'b0;
        mem(1'b1, 1'b0, '0);
        tick();
        check("seq_req0", bus.imem_req, 1);
        check("seq_addr0", bus.imem_addr, 32'h0);
        tick();
        mem(1'b1, 1'b1, 32'h0010_0093);
        check("seq_addr4", bus.imem_addr, 32'h4);
        check("seq_req4", bus.imem_req, 1);
        tick();
        check("seq_ifpc0", IF_ID_pc, 32'h0);
        check("seq_inst0", IF_ID_inst, 32'h0010_0093);
        check("seq_valid0", IF_ID_valid, 1);
        check("seq_rs2_0", IF_ID_rs2, 1);
        mem(1'b1, 1'b1, 32'h0020_8113);
        check("seq_addr8", bus.imem_addr, 32'h8);
        tick();
        check("seq_ifpc4", IF_ID_pc, 32'h4);
        check("seq_rs1_1", IF_ID_rs1, 1);
        check("seq_rs2_1", IF_ID_rs2, 2);
        mem(1'b0, 1'b1, 32'h0031_0193);
        check("seq_addrC", bus.imem_addr, 32'hC);
        tick();
        check("seq_ifpc8", IF_ID_pc, 32'h8);
        check("seq_inst2", IF_ID_inst, 32'h0031_0193);

        // Request held stable until grant; stray rvalid ignored
        mem(1'b0, 1'b0, '0);
        check("hold_req", bus.imem_req, 1);
        check("hold_addr", bus.imem_addr, 32'hC);
        tick();
        check("valid_pulse", IF_ID_valid, 0);
        mem(1'b0, 1'b1, 32'hFFFF_FFFF);
        check("stray_addr", bus.imem_addr, 32'hC);
        tick();
        check("stray_valid", IF_ID_valid, 0);
        check("stray_ifpc", IF_ID_pc, 32'h8);

        // 3-cycle response latency
        mem(1'b1, 1'b0, '0);
        tick();
        mem(1'b0, 1'b0, '0);
        check("lat_req_c1", bus.imem_req, 0);
        tick();
        check("lat_req_c2", bus.imem_req, 0);
        check("lat_valid_c2", IF_ID_valid, 0);
        tick();
        mem(1'b0, 1'b1, 32'h0041_8213);
        check("lat_req_c3", bus.imem_req, 1);
        check("lat_addr_c3", bus.imem_addr, 32'h10);
        tick();
        check("lat_valid", IF_ID_valid, 1);
        check("lat_ifpc", IF_ID_pc, 32'hC);
        check("lat_inst", IF_ID_inst, 32'h0041_8213);
        mem(1'b1, 1'b0, '0);
        tick();
        check("lat_valid_once", IF_ID_valid, 0);

        // Response arrives during a 4-cycle stall
        if_stall = 1'b1;
        mem(1'b0, 1'b1, 32'h00A0_0093);
        check("stall_req_rv", bus.imem_req, 0);
        tick();
        check("stall_inst", IF_ID_inst, 32'h0041_8213);
        check("stall_ifpc", IF_ID_pc, 32'hC);
        mem(1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            check("stall_noreq", bus.imem_req, 0);
            tick();
            check("stall_inst_hold", IF_ID_inst, 32'h0041_8213);
        end
        if_stall = 1'b0;
        #1;
        tick();
        check("unstall_inst", IF_ID_inst, 32'h00A0_0093);
        check("unstall_pc", IF_ID_pc, 32'h10);
        check("unstall_rs1", IF_ID_rs1, 0);
        check("unstall_rs2", IF_ID_rs2, 10);
        check("unstall_valid", IF_ID_valid, 1);
        check("unstall_addr", bus.imem_addr, 32'h14);
        check("unstall_req", bus.imem_req, 1);

        // Redirect with a request outstanding
        mem(1'b1, 1'b0, '0);
        tick();
        mem(1'b0, 1'b0, '0);
        pc_src = 1'b1; pc_branch = 32'h100;
        tick();
        pc_src = 1'b0;
        check("br_bubble", IF_ID_inst, 32'h13);
        check("br_valid", IF_ID_valid, 0);
        check("br_ifpc", IF_ID_pc, 32'h0);
        mem(1'b1, 1'b1, 32'h00B0_0113);
        check("br_req", bus.imem_req, 1);
        check("br_addr", bus.imem_addr, 32'h100);
        tick();
        check("br_drop", IF_ID_inst, 32'h13);
        check("br_drop_valid", IF_ID_valid, 0);
        mem(1'b0, 1'b1, 32'h0050_0293);
        check("br_addr_next", bus.imem_addr, 32'h104);
        tick();
        check("br_tgt_pc", IF_ID_pc, 32'h100);
        check("br_tgt_inst", IF_ID_inst, 32'h0050_0293);

        // Redirect, flush and stall together
        mem(1'b0, 1'b0, '0);
        pc_src = 1'b1; pc_branch = 32'h200; if_flush = 1'b1; if_stall = 1'b1;
        tick();
        pc_src = 1'b0; if_flush = 1'b0; if_stall = 1'b0;
        #1;
        check("all_addr", bus.imem_addr, 32'h200);
        check("all_req", bus.imem_req, 1);
        check("all_bubble", IF_ID_inst, 32'h13);
        check("all_valid", IF_ID_valid, 0);

        // Flush alone: bubble, PC unchanged
        mem(1'b1, 1'b0, '0);
        tick();
        mem(1'b0, 1'b1, 32'h0060_0313);
        tick();
        check("fl_pre_pc", IF_ID_pc, 32'h200);
        mem(1'b0, 1'b0, '0);
        if_flush = 1'b1;
        tick();
        if_flush = 1'b0;
        #1;
        check("fl_bubble", IF_ID_inst, 32'h13);
        check("fl_valid", IF_ID_valid, 0);
        check("fl_addr", bus.imem_addr, 32'h204);

        // PC wrap at the top of the address space
        pc_src = 1'b1; pc_branch = 32'hFFFF_FFFC;
        tick();
        pc_src = 1'b0;
        #1;
        check("wrap_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
        mem(1'b1, 1'b0, '0);
        tick();
        mem(1'b1, 1'b1, 32'h0070_0393);
        check("wrap_req", bus.imem_req, 1);
        check("wrap_addr0", bus.imem_addr, 32'h0);
        tick();
        check("wrap_ifpc", IF_ID_pc, 32'hFFFF_FFFC);
`ifdef IFETCH_PERF_CNT_EN
        check("fetch_cnt", fetch_cnt, 8);
        check("stall_cnt", stall_cnt, 5);
`endif

        // Reset with a request outstanding; late response ignored
        mem(1'b0, 1'b0, '0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem(1'b0, 1'b1, 32'hFFFF_FFFF);
        check("mrst_req", bus.imem_req, 0);
        check("mrst_addr", bus.imem_addr, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
        check("mrst_fetch_cnt", fetch_cnt, 0);
`endif
        tick();
        check("mrst_valid", IF_ID_valid, 0);
        check("mrst_inst", IF_ID_inst, 32'h13);
        check("mrst_req_on", bus.imem_req, 1);
        tick();
        check("mrst_late_valid", IF_ID_valid, 0);
        check("mrst_late_inst", IF_ID_inst, 32'h13);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk  in  1  rising-edge clock, the only clock.
REQ-003 SHALL have port reset  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port pc_src  in  1  branch taken from decode (branch & br_eq); redirects fetch.
REQ-005 SHALL have port pc_branch  in  32  redirect target from decode.
REQ-006 SHALL have port if_stall  in  1  hazard hold; PC and IF/ID register keep their values.
REQ-007 SHALL have port if_flush  in  1  loads a bubble into IF/ID.
REQ-008 SHALL have port imem_req  out  1  instruction memory request.
REQ-009 SHALL have port imem_addr  out  32  request address, word aligned.
REQ-010 SHALL have port imem_gnt  in  1  request accepted in the cycle where imem_req & imem_gnt.
REQ-011 SHALL have port imem_rvalid  in  1  response valid, at least 1 cycle after grant.
REQ-012 SHALL have port imem_rdata  in  32  instruction word, valid with imem_rvalid.
REQ-013 SHALL have ports IF_ID_pc out 32, IF_ID_inst out 32, IF_ID_rs1 out 5, IF_ID_rs2 out 5 and IF_ID_valid out 1: the registered IF/ID stage.

Function
REQ-014 SHALL keep at most one request outstanding (granted, response not yet received).
REQ-015 SHALL implement states IDLE, REQ, WAIT and HOLD.
- IDLE -> REQ one cycle after reset.
- REQ -> WAIT on grant.
- WAIT -> REQ on rvalid when not stalled.
- WAIT -> HOLD on rvalid while if_stall=1.
- HOLD -> REQ when if_stall falls.
REQ-016 SHALL hold imem_req and imem_addr stable in REQ until granted.
REQ-017 SHALL, on rvalid with no stall and no redirect, load the IF/ID register at that clock edge:
- IF_ID_inst = rdata, IF_ID_pc = the fetched PC, IF_ID_valid = 1;
- rs1 = inst[19:15], rs2 = inst[24:20].
REQ-018 SHALL, in that same rvalid cycle, assert imem_req with PC+4 combinationally. With a 1-cycle memory this gives 1 instruction per cycle.
REQ-019 SHALL, while if_stall=1, hold the PC and all IF_ID outputs. A response arriving during the stall SHALL be captured in a one-entry hold buffer and delivered to IF/ID on the first unstalled cycle, with no re-fetch.
REQ-020 SHALL, on pc_src=1, do all of the following:
- set PC to pc_branch;
- load IF/ID with a bubble: inst 32'h0000_0013, valid 0, pc and rs1/rs2 0;
- discard the hold buffer;
- mark any outstanding response as squashed.
REQ-021 SHALL drop a squashed response on arrival, leaving IF/ID untouched, and issue the request to pc_branch in that same cycle.
REQ-022 SHALL treat if_flush as REQ-020 without changing the PC; fetch continues sequentially.
REQ-023 SHALL apply priority reset > pc_src > if_flush > if_stall when these arrive in the same cycle.
REQ-024 SHALL compute PC+4 modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
REQ-025 SHALL ignore imem_rvalid when no request is outstanding.

Reset
REQ-026 SHALL, while reset=1 at a clock edge, set all outputs and state as follows:
- state IDLE, PC = RESET_PC, imem_req = 0, imem_addr = RESET_PC;
- IF_ID_pc 0, IF_ID_inst 32'h0000_0013, IF_ID_rs1/rs2 0, IF_ID_valid 0;
- hold buffer and squash flag cleared.
REQ-027 SHALL, on reset mid-operation, abandon any outstanding request; a late rvalid after reset SHALL be ignored.

Configuration
REQ-028 SHALL, with macro IFETCH_PERF_CNT_EN defined, add two outputs, each cleared by reset and wrapping silently:
- fetch_cnt out 32: counts IF/ID loads with valid=1;
- stall_cnt out 32: counts cycles with if_stall=1.
Without the macro, these ports and their logic SHALL be absent.

Verification
REQ-029 SHALL cover: reset release with 1-cycle memory and gnt=1 -> addresses 0x0, 0x4, 0x8 on consecutive cycles; IF_ID_pc follows one cycle behind.
REQ-030 SHALL cover: memory with 3-cycle rvalid latency -> imem_req low while waiting, one outstanding request, IF_ID_valid pulses once per response.
REQ-031 SHALL cover: rdata 32'h00A0_0093 arrives while if_stall=1 for 4 cycles -> IF/ID unchanged for 4 cycles, then inst 32'h00A0_0093 with rs1 = 0 and rs2 = 10; no duplicate fetch.
REQ-032 SHALL cover: pc_src=1 with pc_branch 0x100 while a request is outstanding -> IF/ID becomes bubble 0x13, the stale response is dropped, the next granted address is 0x100.
REQ-033 SHALL cover: pc_src, if_flush and if_stall all asserted together -> redirect wins, PC = pc_branch.
REQ-034 SHALL cover: PC at 0xFFFF_FFFC -> next request address is 0x0.
